// File: rtl/divider_if.sv
// ---------------------------------------------------------------------------
// divider_if : handshake and operand/result bundle for the divider block.
//
//   start      requester -> divider  request a division (sampled in IDLE)
//   dividend   requester -> divider  unsigned numerator, WIDTH bits
//   divisor    requester -> divider  unsigned denominator, WIDTH bits
//   busy       divider -> requester  division in progress
//   done       divider -> requester  one-cycle pulse, results valid
//   quotient   divider -> requester  unsigned quotient, WIDTH bits
//   remainder  divider -> requester  unsigned remainder, WIDTH bits
//   dbz        divider -> requester  last result was a divide-by-zero
//
// master modport: requester side.  slave modport: the divider.
// ---------------------------------------------------------------------------
interface divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );
endinterface

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider : unsigned restoring shift-subtract divider, one quotient bit per
// clock, WIDTH iterations per division.
//
// Ports
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-low reset
//   bus    divider_if.slave (start/dividend/divisor in,
//          busy/done/quotient/remainder/dbz out)
//
// Timing: a start accepted at edge E0 produces done in the cycle after
// E(WIDTH). A zero divisor skips CALC and produces done in the cycle after
// the accepting edge with quotient all ones, remainder = dividend, dbz = 1.
// Results hold until the next result is registered or reset.
// ---------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;

    logic [WIDTH-1:0] q_r;      // working quotient, dividend shifts out of the top
    logic [WIDTH-1:0] d_r;      // captured divisor
    logic [WIDTH:0]   r_r;      // partial remainder
    logic [CNT_W-1:0] cnt;      // completed iterations

    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;

    logic             accept;
    logic             last;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   trial_sub;
    logic             fits;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    // After every restore R < D, so R's top bit is always zero and never
    // feeds the next trial value.
    logic             unused_rmsb;
    assign unused_rmsb = r_r[WIDTH];

    assign accept = (state == IDLE) && bus.start;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits.
    always_comb begin
        trial     = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
        trial_sub = trial - {1'b0, d_r};
        fits      = (trial >= {1'b0, d_r});
        r_step    = fits ? trial_sub : trial;
        q_step    = {q_r[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r    <= '0;
            d_r    <= '0;
            r_r    <= '0;
            cnt    <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
        end else if (accept) begin
            q_r <= bus.dividend;
            d_r <= bus.divisor;
            r_r <= '0;
            cnt <= '0;
            // Zero divisor goes straight to DONE, so its result is
            // registered on the accepting edge.
            if (bus.divisor == '0) begin
                quot_r <= '1;
                rem_r  <= bus.dividend;
                dbz_r  <= 1'b1;
            end
        end else if (state == CALC) begin
            q_r <= q_step;
            r_r <= r_step;
            cnt <= cnt + 1'b1;
            // Final iteration: register the freshly computed values as DONE
            // is entered on this same edge.
            if (last) begin
                quot_r <= q_step;
                rem_r  <= r_step[WIDTH-1:0];
                dbz_r  <= 1'b0;
            end
        end
    end

    assign bus.busy      = (state == CALC);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
    assign bus.dbz       = dbz_r;

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider : self-checking bench for divider (WIDTH = 16).
// Directed cases plus a randomized back-to-back run compared against a plain
// arithmetic reference (/ and %) and the division identity.
// ---------------------------------------------------------------------------
module tb_divider;
    localparam int W     = 16;
    localparam int NRAND = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    divider_if #(.WIDTH(W)) bus();

    divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] pick_val(input bit nonzero);
        int unsigned s;
        logic [W-1:0] v;
        s = $urandom_range(0, 9);
        case (s)
            0:       v = '0;
            1:       v = '1;
            2:       v = 1;
            3:       v = W'($urandom_range(0, 15));
            default: v = W'($urandom);
        endcase
        if (nonzero && v == 0) v = 1;
        return v;
    endfunction

    // Single division from IDLE: checks latency, busy length, results and
    // that done is a one-cycle pulse.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int lat;
        int busy_n;
        logic [W-1:0] eq, er;
        logic ez;
        model(a, b, eq, er, ez);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, (b == 0) ? 0 : W);
        check({tag, "_busy_cycles"}, busy_n, (b == 0) ? 0 : W);
        check({tag, "_busy_at_done"}, bus.busy, 0);
        check({tag, "_quotient"}, bus.quotient, eq);
        check({tag, "_remainder"}, bus.remainder, er);
        check({tag, "_dbz"}, bus.dbz, ez);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_quotient_hold"}, bus.quotient, eq);
    endtask

    initial begin
        int n_done;
        int w;
        int cyc;
        int last_cyc;
        logic [W-1:0] gq, gr;
        logic [W-1:0] a, b, eq, er;
        logic ez;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.dbz, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_div(16'd100, 16'd7, "d100_7");
        run_div(16'hFFFF, 16'd1, "dffff_1");
        run_div(16'd3, 16'd10, "d3_10");
        run_div(16'd5, 16'd0, "d5_0");
        run_div(16'd9, 16'd3, "d9_3");
        run_div(16'd0, 16'd13, "d0_13");

        // Start pulsed mid-calculation with new operands must be ignored
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd10;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = '0;
        n_done = 0;
        gq = '0;
        gr = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                gq = bus.quotient;
                gr = bus.remainder;
            end
            if (i == 7) begin
                bus.start    = 1'b1;
                bus.dividend = 16'd50;
                bus.divisor  = 16'd5;
            end
            if (i == 8) begin
                bus.start    = 1'b0;
                bus.dividend = 16'd7;
                bus.divisor  = '0;
            end
        end
        check("ignore_start_done_count", n_done, 1);
        check("ignore_start_quotient", gq, 100);
        check("ignore_start_remainder", gr, 0);

        // Reset in the middle of a division aborts it without a done pulse
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_dbz", bus.dbz, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_div(16'd1000, 16'd3, "d1000_3");

        // Randomized back-to-back run with start held high
        a = pick_val(1'b0);
        b = pick_val(1'b1);
        qa.push_back(a);
        qb.push_back(b);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        cyc = 0;
        last_cyc = 0;
        for (int i = 0; i < NRAND; i++) begin
            w = 0;
            do begin
                @(negedge clk);
                cyc++;
                w++;
            end while (!bus.done && w < 60);
            if (!bus.done) begin
                check("rand_timeout", 0, 1);
                break;
            end
            a = qa.pop_front();
            b = qb.pop_front();
            model(a, b, eq, er, ez);
            check("rand_quotient", bus.quotient, eq);
            check("rand_remainder", bus.remainder, er);
            check("rand_dbz", bus.dbz, ez);
            check("rand_identity", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
            check("rand_rem_lt_div", (bus.remainder < b) ? 1 : 0, 1);
            if (i > 0) check("rand_period", cyc - last_cyc, W + 2);
            last_cyc = cyc;
            // DONE ignores start; these operands are taken two edges later
            a = pick_val(1'b0);
            b = pick_val(1'b1);
            qa.push_back(a);
            qb.push_back(b);
            bus.dividend = a;
            bus.divisor  = b;
        end
        bus.start = 1'b0;
        repeat (25) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
